// File: rtl/i2c_master_reg_seq.sv
// i2c_master_reg_seq
// Runs one complete I2C register read or write through the byte controller.
// The sequencer issues one byte command at a time and waits for cmd_ack.
// It ends every transaction with a single done pulse that carries read data
// and at most one error flag (NACK, arbitration lost or watchdog timeout).
module i2c_master_reg_seq #(
    parameter int TO_W     = 16,
    parameter int TO_LIMIT = 0
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack_err,
    output logic       al_err,
    output logic       to_err,
    output logic       bc_start,
    output logic       bc_stop,
    output logic       bc_read,
    output logic       bc_write,
    output logic       bc_ack_in,
    output logic [7:0] bc_din,
    input  logic       bc_cmd_ack,
    input  logic       bc_ack_out,
    input  logic [7:0] bc_dout,
    input  logic       bc_al
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEVW, S_REG, S_WDATA, S_DEVR, S_RDATA, S_STOPO, S_DONE
    } state_t;

    // One byte-controller command: strobes plus the byte and ack to drive
    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } bc_cmd_t;

    // Request fields latched at accept time
    typedef struct packed {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] rreg;
        logic [7:0] wdata;
    } req_t;

    // The watchdog fires on the TO_LIMIT-th cycle after the command is issued
    localparam int              TO_LAST_I = (TO_LIMIT > 0) ? TO_LIMIT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST   = TO_LAST_I[TO_W-1:0];

    function automatic bc_cmd_t wr_cmd(input logic with_start, input logic with_stop,
                                       input logic [7:0] b);
        bc_cmd_t c;
        c        = '0;
        c.start  = with_start;
        c.stop   = with_stop;
        c.write  = 1'b1;
        c.din    = b;
        return c;
    endfunction

    // Final read byte is always NACKed by the master, then stop
    function automatic bc_cmd_t rd_cmd();
        bc_cmd_t c;
        c        = '0;
        c.read   = 1'b1;
        c.stop   = 1'b1;
        c.ack_in = 1'b1;
        return c;
    endfunction

    function automatic bc_cmd_t stop_cmd();
        bc_cmd_t c;
        c      = '0;
        c.stop = 1'b1;
        return c;
    endfunction

    state_t          state;
    bc_cmd_t         cmd;
    req_t            rq;
    logic [TO_W-1:0] wd_cnt;
    logic            wd_hit;

    assign wd_hit    = (TO_LIMIT > 0) && (wd_cnt == TO_LAST);

    assign bc_start  = cmd.start;
    assign bc_stop   = cmd.stop;
    assign bc_read   = cmd.read;
    assign bc_write  = cmd.write;
    assign bc_ack_in = cmd.ack_in;
    assign bc_din    = cmd.din;

    // Sequencer FSM: issues byte commands, tracks outcome, drives all outputs
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            cmd       <= '0;
            rq        <= '0;
            wd_cnt    <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            nack_err  <= 1'b0;
            al_err    <= 1'b0;
            to_err    <= 1'b0;
        end else if (rst) begin
            state     <= S_IDLE;
            cmd       <= '0;
            rq        <= '0;
            wd_cnt    <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            nack_err  <= 1'b0;
            al_err    <= 1'b0;
            to_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        rq        <= '{rnw: req_rnw, dev: req_dev, rreg: req_reg, wdata: req_wdata};
                        nack_err  <= 1'b0;
                        al_err    <= 1'b0;
                        to_err    <= 1'b0;
                        req_ready <= 1'b0;
                        wd_cnt    <= '0;
                        cmd       <= wr_cmd(1'b1, 1'b0, {req_dev, 1'b0});
                        state     <= S_DEVW;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    if (bc_al) begin
                        // Bus is no longer ours: drop everything, no stop
                        cmd    <= '0;
                        al_err <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (bc_cmd_ack) begin
                        wd_cnt <= '0;
                        case (state)
                            S_DEVW: begin
                                if (bc_ack_out) begin
                                    nack_err <= 1'b1;
                                    cmd      <= stop_cmd();
                                    state    <= S_STOPO;
                                end else begin
                                    cmd   <= wr_cmd(1'b0, 1'b0, rq.rreg);
                                    state <= S_REG;
                                end
                            end
                            S_REG: begin
                                if (bc_ack_out) begin
                                    nack_err <= 1'b1;
                                    cmd      <= stop_cmd();
                                    state    <= S_STOPO;
                                end else if (rq.rnw) begin
                                    cmd   <= wr_cmd(1'b1, 1'b0, {rq.dev, 1'b1});
                                    state <= S_DEVR;
                                end else begin
                                    cmd   <= wr_cmd(1'b0, 1'b1, rq.wdata);
                                    state <= S_WDATA;
                                end
                            end
                            S_DEVR: begin
                                if (bc_ack_out) begin
                                    nack_err <= 1'b1;
                                    cmd      <= stop_cmd();
                                    state    <= S_STOPO;
                                end else begin
                                    cmd   <= rd_cmd();
                                    state <= S_RDATA;
                                end
                            end
                            S_WDATA: begin
                                // Stop already went out with the data byte
                                nack_err <= bc_ack_out;
                                cmd      <= '0;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end
                            S_RDATA: begin
                                rdata <= bc_dout;
                                cmd   <= '0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                            S_STOPO: begin
                                cmd   <= '0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                            default: begin
                                cmd   <= '0;
                                state <= S_IDLE;
                            end
                        endcase
                    end else if (wd_hit) begin
                        cmd    <= '0;
                        to_err <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_reg_seq.sv
// Bench for i2c_master_reg_seq: a byte-controller responder that follows a
// per-command action list. It checks the DUT against a byte-sequence model of
// the I2C transaction.
module tb_i2c_master_reg_seq;

    localparam int A_ACK  = 0;
    localparam int A_NACK = 1;
    localparam int A_AL   = 2;
    localparam int A_NONE = 3;
    localparam int TO_LIM = 100;

    logic       clk = 1'b0;
    logic       Reset, rst;
    logic       req_valid, req_ready, req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       done, nack_err, al_err, to_err;
    logic [7:0] rdata;
    logic       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
    logic [7:0] bc_din;
    logic       bc_cmd_ack, bc_ack_out, bc_al;
    logic [7:0] bc_dout;

    int checks = 0;
    int failures = 0;

    // Responder action per command index, and model outputs
    int          acts[8];
    logic [12:0] exp_cmds[8];
    int          nexp;
    logic        e_nack, e_al, e_to, e_rd_ok;
    int          last_wait;

    i2c_master_reg_seq #(.TO_W(16), .TO_LIMIT(TO_LIM)) dut (
        .clk(clk), .Reset(Reset), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .done(done), .rdata(rdata), .nack_err(nack_err), .al_err(al_err), .to_err(to_err),
        .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write),
        .bc_ack_in(bc_ack_in), .bc_din(bc_din),
        .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] cur_cmd();
        return {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
    endfunction

    function automatic void clear_acts();
        for (int i = 0; i < 8; i++) acts[i] = A_ACK;
    endfunction

    // Expected command bytes {start,stop,read,write,ack_in,din} and outcome
    function automatic void build_model(input logic rnw, input logic [6:0] dev,
                                        input logic [7:0] rg, input logic [7:0] wd);
        logic [12:0] seq[4];
        int n;
        seq[0] = {5'b10010, dev, 1'b0};
        seq[1] = {5'b00010, rg};
        seq[3] = '0;
        if (rnw) begin
            seq[2] = {5'b10010, dev, 1'b1};
            seq[3] = {5'b01101, 8'h00};
            n = 4;
        end else begin
            seq[2] = {5'b01010, wd};
            n = 3;
        end
        nexp = 0; e_nack = 0; e_al = 0; e_to = 0; e_rd_ok = 0;
        for (int k = 0; k < n; k++) begin
            exp_cmds[nexp] = seq[k];
            nexp++;
            if (acts[k] == A_AL) begin e_al = 1; break; end
            if (acts[k] == A_NONE) begin e_to = 1; break; end
            if (acts[k] == A_NACK && seq[k][9]) begin
                e_nack = 1;
                if (!seq[k][11]) begin
                    exp_cmds[nexp] = {5'b01000, 8'h00};
                    nexp++;
                end
                break;
            end
            if (k == n - 1 && rnw) e_rd_ok = 1;
        end
    endfunction

    // Run one request; abort_at >= 0 returns once that command index appears
    task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic hold_valid, input int abort_at,
                           input string nm);
        int cyc, nobs, hold, issue_cyc, first_cyc, w, a;
        logic outst, unstable;
        logic [12:0] obs[8];
        logic [12:0] cur;
        logic [7:0] rdv;
        rdv = 8'($urandom);
        build_model(rnw, dev, rg, wd);
        bc_dout = rdv;
        req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        last_wait = w;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: req_ready=%b never 1", nm, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold_valid) req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_drop: got=%b exp=0", nm, req_ready);
        end
        nobs = 0; outst = 0; hold = 0; issue_cyc = 0; first_cyc = -1; unstable = 0;
        for (cyc = 0; cyc < 600; cyc++) begin
            bc_cmd_ack = 1'b0; bc_al = 1'b0; bc_ack_out = 1'b0;
            if (done === 1'b1) break;
            cur = cur_cmd();
            if (!outst) begin
                if (cur[12:9] != 4'b0) begin
                    if (nobs == abort_at) return;
                    if (nobs < 8) obs[nobs] = cur;
                    if (nobs == 0) first_cyc = cyc;
                    nobs++;
                    outst = 1;
                    hold = $urandom_range(0, 4);
                    issue_cyc = cyc;
                end
            end else if (nobs <= 8 && cur !== obs[nobs-1]) begin
                unstable = 1;
            end
            if (outst) begin
                a = (nobs <= 8) ? acts[nobs-1] : A_ACK;
                if (a != A_NONE) begin
                    if (hold == 0) begin
                        if (a == A_AL) bc_al = 1'b1;
                        else begin bc_cmd_ack = 1'b1; bc_ack_out = (a == A_NACK); end
                        outst = 0;
                    end else hold--;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout: no done within budget", nm);
            return;
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL %s stable: strobes changed before cmd_ack", nm);
        end
        checks++;
        if (first_cyc != 0) begin
            failures++;
            $display("FAIL %s first_cmd: first seen at cycle %0d exp 0", nm, first_cyc);
        end
        checks++;
        if (cur_cmd() !== 13'h0) begin
            failures++;
            $display("FAIL %s strobes_at_done: got=%h exp=0", nm, cur_cmd());
        end
        checks++;
        if (nobs != nexp) begin
            failures++;
            $display("FAIL %s ncmds: got=%0d exp=%0d", nm, nobs, nexp);
        end
        for (int i = 0; i < nexp && i < nobs && i < 8; i++) begin
            checks++;
            if (exp_cmds[i][9] ? (obs[i] !== exp_cmds[i]) : (obs[i][12:8] !== exp_cmds[i][12:8])) begin
                failures++;
                $display("FAIL %s cmd%0d: got=%h exp=%h", nm, i, obs[i], exp_cmds[i]);
            end
        end
        checks++;
        if ({nack_err, al_err, to_err} !== {e_nack, e_al, e_to}) begin
            failures++;
            $display("FAIL %s flags: got nack/al/to=%b%b%b exp=%b%b%b", nm,
                     nack_err, al_err, to_err, e_nack, e_al, e_to);
        end
        if (e_rd_ok) begin
            checks++;
            if (rdata !== rdv) begin
                failures++;
                $display("FAIL %s rdata: got=%h exp=%h", nm, rdata, rdv);
            end
        end
        if (e_to) begin
            checks++;
            if (cyc - issue_cyc != TO_LIM) begin
                failures++;
                $display("FAIL %s to_latency: got=%0d exp=%0d", nm, cyc - issue_cyc, TO_LIM);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s after_done: got done/ready=%b%b exp=01", nm, done, req_ready);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        checks++;
        if ({req_ready, done, nack_err, al_err, to_err, rdata, cur_cmd()} !== {1'b1, 4'b0, 8'h00, 13'h0}) begin
            failures++;
            $display("FAIL %s idle_outs: ready=%b done=%b err=%b%b%b rdata=%h cmd=%h exp ready=1 rest 0",
                     nm, req_ready, done, nack_err, al_err, to_err, rdata, cur_cmd());
        end
    endtask

    task automatic watch_no_done(input string nm);
        logic seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (seen || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s no_done: done_seen=%b ready=%b exp 0/1", nm, seen, req_ready);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; rst = 1'b0; req_valid = 1'b0; req_rnw = 0; req_dev = 0; req_reg = 0;
        req_wdata = 0; bc_cmd_ack = 0; bc_ack_out = 0; bc_al = 0; bc_dout = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_asserted");
        Reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_write();
        clear_acts();
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, -1, "write");
    endtask

    task automatic test_read();
        clear_acts();
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 1'b0, -1, "read");
    endtask

    task automatic test_nack();
        clear_acts(); acts[0] = A_NACK;
        run_txn(1'b0, 7'h50, 8'h10, 8'h5A, 1'b0, -1, "nack_addr");
        clear_acts(); acts[2] = A_NACK;
        run_txn(1'b0, 7'h21, 8'h33, 8'h44, 1'b0, -1, "nack_wdata");
        clear_acts(); acts[3] = A_NACK;
        run_txn(1'b1, 7'h21, 8'h34, 8'h00, 1'b0, -1, "nack_rdata_ignored");
    endtask

    task automatic test_al();
        clear_acts(); acts[1] = A_AL;
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, -1, "al_reg");
        clear_acts();
        run_txn(1'b1, 7'h50, 8'h11, 8'h00, 1'b0, -1, "after_al");
    endtask

    task automatic test_timeout();
        clear_acts(); acts[0] = A_NONE;
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, -1, "timeout_devw");
        clear_acts(); acts[3] = A_NONE;
        run_txn(1'b1, 7'h3A, 8'h01, 8'h00, 1'b0, -1, "timeout_rdata");
    endtask

    task automatic test_back_to_back();
        clear_acts();
        run_txn(1'b0, 7'h12, 8'h34, 8'h56, 1'b1, -1, "b2b_first");
        run_txn(1'b1, 7'h65, 8'h43, 8'h00, 1'b0, -1, "b2b_second");
        checks++;
        if (last_wait != 0) begin
            failures++;
            $display("FAIL b2b accept_delay: got=%0d exp=0", last_wait);
        end
    endtask

    task automatic test_reset_mid();
        clear_acts();
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 1'b0, 2, "reset_mid");
        bc_cmd_ack = 0; bc_al = 0; bc_ack_out = 0;
        #1 Reset = 1'b1;
        #1 check_idle_outputs("reset_mid_devr");
        @(negedge clk);
        Reset = 1'b0;
        watch_no_done("reset_mid");
        clear_acts();
        run_txn(1'b0, 7'h0F, 8'hF0, 8'h99, 1'b0, 1, "rst_mid");
        bc_cmd_ack = 0; bc_al = 0; bc_ack_out = 0;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid_reg");
        rst = 1'b0;
        watch_no_done("rst_mid");
        clear_acts();
        run_txn(1'b1, 7'h44, 8'h55, 8'h00, 1'b0, -1, "after_rst");
    endtask

    task automatic test_random();
        logic rnw;
        int n, f;
        for (int t = 0; t < 30; t++) begin
            rnw = 1'($urandom);
            n = rnw ? 4 : 3;
            clear_acts();
            f = $urandom_range(0, 6);
            if (f >= 1 && f <= 3) acts[$urandom_range(0, n - 1)] = A_NACK;
            else if (f == 4 || f == 5) acts[$urandom_range(0, n - 1)] = A_AL;
            else if (f == 6 && t % 5 == 0) acts[$urandom_range(0, n - 1)] = A_NONE;
            run_txn(rnw, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), -1, "random");
            req_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_al();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
